// File: rtl/mac_fifo_feeder_pkg.sv
// Shared constants, state type and helpers for the MAC FIFO feeder.
package mac_fifo_feeder_pkg;

    localparam int DATA_W   = 32;
    localparam int GROUP    = 3;
    localparam int NUM_COEF = 8;
    localparam int CA_W     = $clog2(NUM_COEF);
    localparam int GI_W     = $clog2(GROUP);
    localparam int WORD_W   = GROUP * DATA_W;

    typedef enum logic {
        S_SAMPLE,
        S_COEF
    } feed_state_t;

    // Coefficient write address advance, wrapping at the top of the bank
    function automatic logic [CA_W-1:0] nextCoefAddr(input logic [CA_W-1:0] addr);
        return (addr == CA_W'(NUM_COEF - 1)) ? '0 : addr + 1'b1;
    endfunction

endpackage

// File: rtl/mac_fifo_feeder_if.sv
// Sample/coefficient input port and FIFO/coefficient-bank write port of the feeder.
interface mac_fifo_feeder_if;
    import mac_fifo_feeder_pkg::*;

    logic              PushIn;
    logic [DATA_W-1:0] DataIn;
    logic              StopIn;
    logic              PushCoef;
    logic [DATA_W-1:0] CoefIn;
    logic              fifo_full;
    logic              fifo_PushOut;
    logic [WORD_W-1:0] fifo_DataOut;
    logic              coef_we;
    logic [CA_W-1:0]   coef_addr;
    logic [DATA_W-1:0] coef_data;
    logic              coef_done;
    logic              collide_err;

    modport slave (
        input  PushIn, DataIn, PushCoef, CoefIn, fifo_full,
        output StopIn, fifo_PushOut, fifo_DataOut,
               coef_we, coef_addr, coef_data, coef_done, collide_err
    );

    modport master (
        output PushIn, DataIn, PushCoef, CoefIn, fifo_full,
        input  StopIn, fifo_PushOut, fifo_DataOut,
               coef_we, coef_addr, coef_data, coef_done, collide_err
    );

endinterface

// File: rtl/mac_fifo_feeder_sample_packer.sv
// Collects GROUP consecutive samples into one wide word, slot 0 in the LSBs.
module mac_fifo_feeder_sample_packer
    import mac_fifo_feeder_pkg::*;
(
    input  logic              Clk,
    input  logic              Reset,
    input  logic              i_accept,
    input  logic              i_clear,
    input  logic [DATA_W-1:0] i_data,
    output logic [GI_W-1:0]   o_groupIdx,
    output logic              o_groupDone,
    output logic [WORD_W-1:0] o_packedWord
);

    logic [GI_W-1:0]   r_groupIdx;
    logic [WORD_W-1:0] r_pack;
    logic              w_lastSlot;

    assign w_lastSlot   = (r_groupIdx == GI_W'(GROUP - 1));
    assign o_groupDone  = i_accept & w_lastSlot;
    assign o_groupIdx   = r_groupIdx;

    // The completed word includes the sample arriving this cycle in its slot
    always_comb begin
        o_packedWord = r_pack;
        o_packedWord[r_groupIdx*DATA_W +: DATA_W] = i_data;
    end

    // Slot counter and storage; a clear drops any partial group
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_groupIdx <= '0;
            r_pack     <= '0;
        end else if (i_clear) begin
            r_groupIdx <= '0;
        end else if (i_accept) begin
            r_pack[r_groupIdx*DATA_W +: DATA_W] <= i_data;
            r_groupIdx <= w_lastSlot ? '0 : r_groupIdx + 1'b1;
        end
    end

endmodule

// File: rtl/mac_fifo_feeder.sv
// Write-side producer for the MAC sample FIFO and coefficient bank loader.
module mac_fifo_feeder
    import mac_fifo_feeder_pkg::*;
(
    input  logic               Clk,
    input  logic               Reset,
    mac_fifo_feeder_if.slave   io_feed
);

    feed_state_t       r_state;
    feed_state_t       w_nextState;
    logic              w_addrClear;

    logic              w_stop;
    logic              w_accept;
    logic              w_push;
    logic [GI_W-1:0]   w_groupIdx;
    logic              w_groupDone;
    logic [WORD_W-1:0] w_packedWord;

    logic [WORD_W-1:0] r_outReg;
    logic              r_outValid;

    logic [CA_W-1:0]   r_coefAddr;
    logic [CA_W-1:0]   r_coefAddrOut;
    logic [DATA_W-1:0] r_coefData;
    logic              r_coefWe;
    logic              r_coefDone;
    logic              r_collideErr;

    // Stop only when a word is pending and the next sample would complete another
    assign w_stop   = r_outValid & (w_groupIdx == GI_W'(GROUP - 1));
    assign w_accept = io_feed.PushIn & ~w_stop & ~io_feed.PushCoef;
    assign w_push   = r_outValid & ~io_feed.fifo_full;

    mac_fifo_feeder_sample_packer u_packer (
        .Clk          (Clk),
        .Reset        (Reset),
        .i_accept     (w_accept),
        .i_clear      (io_feed.PushCoef),
        .i_data       (io_feed.DataIn),
        .o_groupIdx   (w_groupIdx),
        .o_groupDone  (w_groupDone),
        .o_packedWord (w_packedWord)
    );

    // Mode register
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state <= S_SAMPLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Mode transitions; leaving coefficient mode starts a new coefficient frame
    always_comb begin
        w_nextState = r_state;
        w_addrClear = 1'b0;
        case (r_state)
            S_SAMPLE: begin
                if (io_feed.PushCoef) begin
                    w_nextState = S_COEF;
                end
            end
            S_COEF: begin
                if (io_feed.PushIn && !io_feed.PushCoef) begin
                    w_nextState = S_SAMPLE;
                    w_addrClear = 1'b1;
                end
            end
            default: begin
                w_nextState = S_SAMPLE;
            end
        endcase
    end

    // Output word holding register; a completing group can never collide with a pending word
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_outReg   <= '0;
            r_outValid <= 1'b0;
        end else if (w_groupDone) begin
            r_outReg   <= w_packedWord;
            r_outValid <= 1'b1;
        end else if (w_push) begin
            r_outValid <= 1'b0;
        end
    end

    // Registered coefficient bank write port and wrapping address
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_coefAddr    <= '0;
            r_coefAddrOut <= '0;
            r_coefData    <= '0;
            r_coefWe      <= 1'b0;
            r_coefDone    <= 1'b0;
            r_collideErr  <= 1'b0;
        end else begin
            r_coefWe     <= io_feed.PushCoef;
            r_coefDone   <= io_feed.PushCoef & (r_coefAddr == CA_W'(NUM_COEF - 1));
            r_collideErr <= io_feed.PushIn & io_feed.PushCoef;
            if (io_feed.PushCoef) begin
                r_coefData    <= io_feed.CoefIn;
                r_coefAddrOut <= r_coefAddr;
                r_coefAddr    <= nextCoefAddr(r_coefAddr);
            end else if (w_addrClear) begin
                r_coefAddr    <= '0;
            end
        end
    end

    assign io_feed.StopIn       = w_stop;
    assign io_feed.fifo_PushOut = w_push;
    assign io_feed.fifo_DataOut = r_outReg;
    assign io_feed.coef_we      = r_coefWe;
    assign io_feed.coef_addr    = r_coefAddrOut;
    assign io_feed.coef_data    = r_coefData;
    assign io_feed.coef_done    = r_coefDone;
    assign io_feed.collide_err  = r_collideErr;

endmodule

// File: tb/tb_mac_fifo_feeder.sv
// Directed self-checking bench for the MAC FIFO feeder.
module tb_mac_fifo_feeder;
    import mac_fifo_feeder_pkg::*;

    logic Clk;
    logic Reset;
    int   checks;
    int   failures;

    mac_fifo_feeder_if bus ();

    mac_fifo_feeder dut (
        .Clk     (Clk),
        .Reset   (Reset),
        .io_feed (bus.slave)
    );

    // Free-running clock, 10 time units per period
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Drive one cycle of pushes from a falling edge, then drop the strobes
    task automatic applyStimulus(input logic pIn, input logic [DATA_W-1:0] d,
                                 input logic pC, input logic [DATA_W-1:0] c);
        bus.PushIn   = pIn;
        bus.DataIn   = d;
        bus.PushCoef = pC;
        bus.CoefIn   = c;
        @(negedge Clk);
        bus.PushIn   = 1'b0;
        bus.PushCoef = 1'b0;
    endtask

    task automatic applyReset();
        Reset         = 1'b1;
        bus.PushIn    = 1'b0;
        bus.PushCoef  = 1'b0;
        bus.DataIn    = '0;
        bus.CoefIn    = '0;
        bus.fifo_full = 1'b0;
        @(negedge Clk);
        @(negedge Clk);
        Reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [WORD_W+DATA_W+CA_W+4:0] obs;
        @(negedge Clk);
        obs = {bus.StopIn, bus.fifo_PushOut, bus.coef_we, bus.coef_done, bus.collide_err,
               bus.coef_addr, bus.coef_data, bus.fifo_DataOut};
        checks++;
        if (obs !== '0) begin
            failures++;
            $display("[TB] FAIL reset_outputs: got %h expected 0", obs);
        end
        applyReset();
    endtask

    task automatic test_basic_pack();
        logic [WORD_W-1:0] exp;
        applyReset();
        applyStimulus(1'b1, 32'h1, 1'b0, '0);
        applyStimulus(1'b1, 32'h2, 1'b0, '0);
        checks++;
        if (bus.fifo_PushOut !== 1'b0) begin
            failures++;
            $display("[TB] FAIL basic_early_push: got %b expected 0", bus.fifo_PushOut);
        end
        applyStimulus(1'b1, 32'h3, 1'b0, '0);
        exp = {32'h3, 32'h2, 32'h1};
        checks++;
        if (bus.fifo_PushOut !== 1'b1) begin
            failures++;
            $display("[TB] FAIL basic_push1: got %b expected 1", bus.fifo_PushOut);
        end
        checks++;
        if (bus.fifo_DataOut !== exp) begin
            failures++;
            $display("[TB] FAIL basic_data1: got %h expected %h", bus.fifo_DataOut, exp);
        end
        applyStimulus(1'b1, 32'h4, 1'b0, '0);
        checks++;
        if (bus.fifo_PushOut !== 1'b0) begin
            failures++;
            $display("[TB] FAIL basic_push1_clear: got %b expected 0", bus.fifo_PushOut);
        end
        applyStimulus(1'b1, 32'h5, 1'b0, '0);
        applyStimulus(1'b1, 32'h6, 1'b0, '0);
        exp = {32'h6, 32'h5, 32'h4};
        checks++;
        if (bus.fifo_PushOut !== 1'b1 || bus.fifo_DataOut !== exp) begin
            failures++;
            $display("[TB] FAIL basic_push2: got %b/%h expected 1/%h", bus.fifo_PushOut, bus.fifo_DataOut, exp);
        end
        applyStimulus(1'b0, '0, 1'b0, '0);
        checks++;
        if (bus.fifo_PushOut !== 1'b0) begin
            failures++;
            $display("[TB] FAIL basic_idle: got %b expected 0", bus.fifo_PushOut);
        end
    endtask

    task automatic test_backpressure();
        logic [WORD_W-1:0] exp;
        applyReset();
        bus.fifo_full = 1'b1;
        applyStimulus(1'b1, 32'h1, 1'b0, '0);
        applyStimulus(1'b1, 32'h2, 1'b0, '0);
        applyStimulus(1'b1, 32'h3, 1'b0, '0);
        checks++;
        if (bus.fifo_PushOut !== 1'b0 || bus.StopIn !== 1'b0) begin
            failures++;
            $display("[TB] FAIL bp_pending: push/stop got %b/%b expected 0/0", bus.fifo_PushOut, bus.StopIn);
        end
        applyStimulus(1'b1, 32'h4, 1'b0, '0);
        checks++;
        if (bus.StopIn !== 1'b0) begin
            failures++;
            $display("[TB] FAIL bp_stop_early: got %b expected 0", bus.StopIn);
        end
        applyStimulus(1'b1, 32'h5, 1'b0, '0);
        checks++;
        if (bus.StopIn !== 1'b1) begin
            failures++;
            $display("[TB] FAIL bp_stop_set: got %b expected 1", bus.StopIn);
        end
        bus.PushIn = 1'b1;
        bus.DataIn = 32'h6;
        @(negedge Clk);
        checks++;
        if (bus.StopIn !== 1'b1 || bus.fifo_PushOut !== 1'b0) begin
            failures++;
            $display("[TB] FAIL bp_hold: stop/push got %b/%b expected 1/0", bus.StopIn, bus.fifo_PushOut);
        end
        bus.fifo_full = 1'b0;
        #1;
        exp = {32'h3, 32'h2, 32'h1};
        checks++;
        if (bus.fifo_PushOut !== 1'b1 || bus.fifo_DataOut !== exp) begin
            failures++;
            $display("[TB] FAIL bp_release1: got %b/%h expected 1/%h", bus.fifo_PushOut, bus.fifo_DataOut, exp);
        end
        @(negedge Clk);
        checks++;
        if (bus.StopIn !== 1'b0 || bus.fifo_PushOut !== 1'b0) begin
            failures++;
            $display("[TB] FAIL bp_after_push: stop/push got %b/%b expected 0/0", bus.StopIn, bus.fifo_PushOut);
        end
        @(negedge Clk);
        bus.PushIn = 1'b0;
        exp = {32'h6, 32'h5, 32'h4};
        checks++;
        if (bus.fifo_PushOut !== 1'b1 || bus.fifo_DataOut !== exp) begin
            failures++;
            $display("[TB] FAIL bp_release2: got %b/%h expected 1/%h", bus.fifo_PushOut, bus.fifo_DataOut, exp);
        end
        @(negedge Clk);
        checks++;
        if (bus.fifo_PushOut !== 1'b0) begin
            failures++;
            $display("[TB] FAIL bp_drained: got %b expected 0", bus.fifo_PushOut);
        end
    endtask

    task automatic test_coef_discard();
        logic [WORD_W-1:0] exp;
        applyReset();
        applyStimulus(1'b1, 32'h11, 1'b0, '0);
        applyStimulus(1'b1, 32'h22, 1'b0, '0);
        applyStimulus(1'b0, '0, 1'b1, 32'hA);
        checks++;
        if (bus.coef_we !== 1'b1 || bus.coef_addr !== CA_W'(0) || bus.coef_data !== 32'hA) begin
            failures++;
            $display("[TB] FAIL discard_coef: we/addr/data got %b/%0d/%h expected 1/0/a",
                     bus.coef_we, bus.coef_addr, bus.coef_data);
        end
        checks++;
        if (bus.fifo_PushOut !== 1'b0 || bus.coef_done !== 1'b0) begin
            failures++;
            $display("[TB] FAIL discard_nopush: push/done got %b/%b expected 0/0", bus.fifo_PushOut, bus.coef_done);
        end
        applyStimulus(1'b1, 32'h33, 1'b0, '0);
        checks++;
        if (bus.coef_we !== 1'b0) begin
            failures++;
            $display("[TB] FAIL discard_we_clear: got %b expected 0", bus.coef_we);
        end
        applyStimulus(1'b1, 32'h44, 1'b0, '0);
        applyStimulus(1'b1, 32'h55, 1'b0, '0);
        exp = {32'h55, 32'h44, 32'h33};
        checks++;
        if (bus.fifo_PushOut !== 1'b1 || bus.fifo_DataOut !== exp) begin
            failures++;
            $display("[TB] FAIL discard_regroup: got %b/%h expected 1/%h", bus.fifo_PushOut, bus.fifo_DataOut, exp);
        end
    endtask

    task automatic test_coef_wrap();
        logic [CA_W-1:0]   expAddr;
        logic [DATA_W-1:0] expData;
        logic              expDone;
        applyReset();
        for (int i = 0; i <= NUM_COEF; i++) begin
            applyStimulus(1'b0, '0, 1'b1, DATA_W'(32'h100 + i));
            expAddr = CA_W'(i % NUM_COEF);
            expData = DATA_W'(32'h100 + i);
            expDone = (i == NUM_COEF - 1);
            checks++;
            if (bus.coef_we !== 1'b1 || bus.coef_addr !== expAddr || bus.coef_data !== expData
                || bus.coef_done !== expDone) begin
                failures++;
                $display("[TB] FAIL wrap_write%0d: we/addr/data/done got %b/%0d/%h/%b expected 1/%0d/%h/%b",
                         i, bus.coef_we, bus.coef_addr, bus.coef_data, bus.coef_done, expAddr, expData, expDone);
            end
        end
        applyStimulus(1'b1, 32'h5, 1'b0, '0);
        applyStimulus(1'b0, '0, 1'b1, 32'h300);
        checks++;
        if (bus.coef_we !== 1'b1 || bus.coef_addr !== CA_W'(0) || bus.coef_done !== 1'b0) begin
            failures++;
            $display("[TB] FAIL wrap_new_frame: we/addr/done got %b/%0d/%b expected 1/0/0",
                     bus.coef_we, bus.coef_addr, bus.coef_done);
        end
    endtask

    task automatic test_collision();
        logic [WORD_W-1:0] exp;
        applyReset();
        applyStimulus(1'b0, '0, 1'b1, 32'hB);
        applyStimulus(1'b1, 32'hDEAD, 1'b1, 32'hC);
        checks++;
        if (bus.coef_we !== 1'b1 || bus.coef_addr !== CA_W'(1) || bus.coef_data !== 32'hC
            || bus.collide_err !== 1'b1) begin
            failures++;
            $display("[TB] FAIL collide_write: we/addr/data/err got %b/%0d/%h/%b expected 1/1/c/1",
                     bus.coef_we, bus.coef_addr, bus.coef_data, bus.collide_err);
        end
        applyStimulus(1'b1, 32'h7, 1'b0, '0);
        checks++;
        if (bus.collide_err !== 1'b0 || bus.coef_we !== 1'b0) begin
            failures++;
            $display("[TB] FAIL collide_pulse: err/we got %b/%b expected 0/0", bus.collide_err, bus.coef_we);
        end
        applyStimulus(1'b1, 32'h8, 1'b0, '0);
        applyStimulus(1'b1, 32'h9, 1'b0, '0);
        exp = {32'h9, 32'h8, 32'h7};
        checks++;
        if (bus.fifo_PushOut !== 1'b1 || bus.fifo_DataOut !== exp) begin
            failures++;
            $display("[TB] FAIL collide_dropped: got %b/%h expected 1/%h", bus.fifo_PushOut, bus.fifo_DataOut, exp);
        end
    endtask

    task automatic test_reset_mid();
        logic [WORD_W+DATA_W+CA_W+4:0] obs;
        applyReset();
        bus.fifo_full = 1'b1;
        applyStimulus(1'b0, '0, 1'b1, 32'h77);
        for (int i = 1; i <= 5; i++) begin
            applyStimulus(1'b1, DATA_W'(i), 1'b0, '0);
        end
        checks++;
        if (bus.StopIn !== 1'b1 || bus.coef_data !== 32'h77) begin
            failures++;
            $display("[TB] FAIL midreset_setup: stop/coef got %b/%h expected 1/77", bus.StopIn, bus.coef_data);
        end
        Reset = 1'b1;
        #1;
        obs = {bus.StopIn, bus.fifo_PushOut, bus.coef_we, bus.coef_done, bus.collide_err,
               bus.coef_addr, bus.coef_data, bus.fifo_DataOut};
        checks++;
        if (obs !== '0) begin
            failures++;
            $display("[TB] FAIL midreset_outputs: got %h expected 0", obs);
        end
        @(negedge Clk);
        Reset         = 1'b0;
        bus.fifo_full = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            checks++;
            if (bus.fifo_PushOut !== 1'b0) begin
                failures++;
                $display("[TB] FAIL midreset_nopush%0d: got %b expected 0", i, bus.fifo_PushOut);
            end
        end
    endtask

    // Run every scenario in order, then report
    initial begin
        checks        = 0;
        failures      = 0;
        Reset         = 1'b1;
        bus.PushIn    = 1'b0;
        bus.PushCoef  = 1'b0;
        bus.DataIn    = '0;
        bus.CoefIn    = '0;
        bus.fifo_full = 1'b0;
        test_reset();
        test_basic_pack();
        test_backpressure();
        test_coef_discard();
        test_coef_wrap();
        test_collision();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
